// File: rtl/spy_event_reader_if.sv
// Bundles the FIFO read port and the forwarded event stream of spy_event_reader.
interface spy_event_reader_if #(
   parameter int DATA_WIDTH = 32
);
   logic [DATA_WIDTH:0] fifo_data;
   logic                fifo_empty;
   logic                fifo_read_enable;
   logic [DATA_WIDTH:0] out_data;
   logic                out_valid;
   logic                out_ready;
   logic                out_sop;
   logic                out_eop;
   logic                out_err;

   // Stream handshake: a beat transfers on a clock edge where out_valid && out_ready;
   // while out_valid && !out_ready, out_data/out_sop/out_eop/out_err are held stable.
   modport slave (
      input  fifo_data, fifo_empty, out_ready,
      output fifo_read_enable, out_data, out_valid, out_sop, out_eop, out_err
   );

   modport master (
      output fifo_data, fifo_empty, out_ready,
      input  fifo_read_enable, out_data, out_valid, out_sop, out_eop, out_err
   );
endinterface

// File: rtl/spy_event_reader.sv
// Pops the spy FIFO, checks header/data/footer framing and forwards events
// through a 2-entry skid buffer with event/word statistics and sticky errors.
module spy_event_reader #(
   parameter int DATA_WIDTH      = 32,
   parameter int MAX_EVENT_WORDS = 1024,
   parameter int WCOUNT_WIDTH    = 11,
   parameter int ECOUNT_WIDTH    = 16
) (
   input  logic                    clock,
   input  logic                    reset,
   spy_event_reader_if.slave       bus,
   input  logic                    clear_errors,
   output logic [ECOUNT_WIDTH-1:0] event_count,
   output logic [WCOUNT_WIDTH-1:0] last_event_words,
   output logic                    err_orphan,
   output logic                    err_overflow,
   output logic [1:0]              fsm_state
);
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      IN_EVENT = 2'd1,
      DROP     = 2'd2
   } state_t;

   localparam int EW = DATA_WIDTH + 4;
   localparam logic [WCOUNT_WIDTH-1:0] MAX_WORDS = WCOUNT_WIDTH'(MAX_EVENT_WORDS);

   state_t                  state;
   state_t                  state_next;
   logic [WCOUNT_WIDTH-1:0] word_count;
   logic [1:0]              occupancy;
   logic [EW-1:0]           entry0;
   logic [EW-1:0]           entry1;
   logic [EW-1:0]           enq_entry;
   logic                    pop;
   logic                    tag;
   logic                    enq;
   logic                    deq;
   logic                    enq_sop;
   logic                    enq_eop;
   logic                    enq_err;
   logic                    clear_count;
   logic                    inc_count;
   logic                    close_event;
   logic                    set_orphan;
   logic                    set_overflow;
   logic [WCOUNT_WIDTH-1:0] close_words;

   // Pop decision uses registered occupancy only, so out_ready never reaches the FIFO.
   assign pop                  = !bus.fifo_empty && (occupancy < 2'd2);
   assign bus.fifo_read_enable = pop && reset;
   assign tag                  = bus.fifo_data[DATA_WIDTH];
   assign deq                  = bus.out_valid && bus.out_ready;
   assign enq_entry            = {enq_err, enq_eop, enq_sop, bus.fifo_data};

   assign bus.out_valid = (occupancy != 2'd0);
   assign {bus.out_err, bus.out_eop, bus.out_sop, bus.out_data} = entry0;
   assign fsm_state     = state;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next   = state;
      enq          = 1'b0;
      enq_sop      = 1'b0;
      enq_eop      = 1'b0;
      enq_err      = 1'b0;
      clear_count  = 1'b0;
      inc_count    = 1'b0;
      close_event  = 1'b0;
      close_words  = word_count;
      set_orphan   = 1'b0;
      set_overflow = 1'b0;
      if (pop) begin
         case (state)
            IDLE: begin
               if (tag) begin
                  enq         = 1'b1;
                  enq_sop     = 1'b1;
                  clear_count = 1'b1;
                  state_next  = IN_EVENT;
               end else begin
                  set_orphan = 1'b1;
               end
            end
            IN_EVENT: begin
               if (tag) begin
                  enq         = 1'b1;
                  enq_eop     = 1'b1;
                  close_event = 1'b1;
                  state_next  = IDLE;
               end else if (word_count == MAX_WORDS) begin
                  set_overflow = 1'b1;
                  state_next   = DROP;
               end else begin
                  enq       = 1'b1;
                  inc_count = 1'b1;
               end
            end
            DROP: begin
               if (tag) begin
                  enq         = 1'b1;
                  enq_eop     = 1'b1;
                  enq_err     = 1'b1;
                  close_event = 1'b1;
                  close_words = MAX_WORDS;
                  state_next  = IDLE;
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   // Skid buffer: entry0 is the head; enqueue only happens with occupancy < 2.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         occupancy <= 2'd0;
         entry0    <= '0;
         entry1    <= '0;
      end else begin
         case ({enq, deq})
            2'b10: begin
               if (occupancy == 2'd0) entry0 <= enq_entry;
               else                   entry1 <= enq_entry;
               occupancy <= occupancy + 2'd1;
            end
            2'b01: begin
               entry0    <= entry1;
               occupancy <= occupancy - 2'd1;
            end
            2'b11: begin
               if (occupancy == 2'd1) begin
                  entry0 <= enq_entry;
               end else begin
                  entry0 <= entry1;
                  entry1 <= enq_entry;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         word_count       <= '0;
         event_count      <= '0;
         last_event_words <= '0;
         err_orphan       <= 1'b0;
         err_overflow     <= 1'b0;
      end else begin
         if (clear_count)    word_count <= '0;
         else if (inc_count) word_count <= word_count + WCOUNT_WIDTH'(1);
         if (close_event) begin
            last_event_words <= close_words;
            event_count      <= event_count + ECOUNT_WIDTH'(1);
         end
         // A new error in the same cycle wins over clear_errors.
         if (set_orphan)        err_orphan <= 1'b1;
         else if (clear_errors) err_orphan <= 1'b0;
         if (set_overflow)      err_overflow <= 1'b1;
         else if (clear_errors) err_overflow <= 1'b0;
      end
   end
endmodule

// File: tb/tb_spy_event_reader.sv
// Bench for spy_event_reader: FIFO model feeding the DUT, framing reference
// model filling an expected-beat queue, and a stream monitor comparing beats.
module tb_spy_event_reader;
  localparam int DW   = 32;
  localparam int MAXW = 4;
  localparam int WCW  = 11;
  localparam int ECW  = 3;
  localparam int EW   = DW + 4;

  logic           clock = 1'b0;
  logic           reset = 1'b0;
  logic           clear_errors = 1'b0;
  logic [ECW-1:0] event_count;
  logic [WCW-1:0] last_event_words;
  logic           err_orphan;
  logic           err_overflow;
  logic [1:0]     fsm_state;

  spy_event_reader_if #(.DATA_WIDTH(DW)) bus ();

  spy_event_reader #(
    .DATA_WIDTH(DW), .MAX_EVENT_WORDS(MAXW), .WCOUNT_WIDTH(WCW), .ECOUNT_WIDTH(ECW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus),
    .clear_errors(clear_errors),
    .event_count(event_count),
    .last_event_words(last_event_words),
    .err_orphan(err_orphan),
    .err_overflow(err_overflow),
    .fsm_state(fsm_state)
  );

  always #5 clock = ~clock;

  logic [DW:0]    fifo_q[$];
  logic [EW-1:0]  exp_q[$];
  int             checks = 0;
  int             errors = 0;
  int             cyc = 0;
  int             ready_mode = 0;
  int             beat_total = 0;
  int             mark = 0;
  int             first_beat_cyc = 0;
  int             last_beat_cyc = 0;
  logic           rd;
  logic           held_valid = 1'b0;
  logic [EW-1:0]  held_beat;
  logic [EW-1:0]  beat;
  logic [EW-1:0]  exp_beat;

  // Reference framing model
  int             m_state;
  int             m_count;
  logic [ECW-1:0] m_ev;
  logic [WCW-1:0] m_last;
  logic           m_orphan;
  logic           m_ovf;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_count = 0; m_ev = '0; m_last = '0; m_orphan = 1'b0; m_ovf = 1'b0;
  endtask

  task automatic model_word(input logic [DW:0] w);
    case (m_state)
      0: if (w[DW]) begin
           exp_q.push_back({3'b001, w}); m_count = 0; m_state = 1;
         end else m_orphan = 1'b1;
      1: if (w[DW]) begin
           exp_q.push_back({3'b010, w}); m_last = WCW'(m_count); m_ev = m_ev + 1'b1; m_state = 0;
         end else if (m_count == MAXW) begin
           m_ovf = 1'b1; m_state = 2;
         end else begin
           exp_q.push_back({3'b000, w}); m_count++;
         end
      default: if (w[DW]) begin
           exp_q.push_back({3'b110, w}); m_last = WCW'(MAXW); m_ev = m_ev + 1'b1; m_state = 0;
         end
    endcase
  endtask

  task automatic drive_fifo();
    bus.fifo_empty = (fifo_q.size() == 0);
    bus.fifo_data  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
  endtask

  task automatic send(input logic [DW:0] w);
    model_word(w);
    fifo_q.push_back(w);
    drive_fifo();
  endtask

  task automatic send_event(input int n_data);
    send({1'b1, 32'($urandom())});
    for (int i = 0; i < n_data; i++) send({1'b0, 32'($urandom())});
    send({1'b1, 32'($urandom())});
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || fifo_q.size() != 0) && t < 300) begin
      @(posedge clock);
      t++;
    end
    cycles(2);
    check("drain_left", 64'(exp_q.size() + fifo_q.size()), 64'd0);
  endtask

  task automatic check_stats(input string tag);
    check({tag, "_event_count"}, 64'(event_count), 64'(m_ev));
    check({tag, "_last_words"}, 64'(last_event_words), 64'(m_last));
    check({tag, "_err_orphan"}, 64'(err_orphan), 64'(m_orphan));
    check({tag, "_err_overflow"}, 64'(err_overflow), 64'(m_ovf));
  endtask

  // FIFO pop and out_ready driver, updated just after each rising edge
  initial begin
    forever begin
      @(posedge clock);
      rd = bus.fifo_read_enable;
      cyc++;
      #1;
      if (rd && fifo_q.size() != 0) fifo_q.delete(0);
      drive_fifo();
      case (ready_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = 1'b0;
        default: bus.out_ready = ~bus.out_ready;
      endcase
    end
  end

  // Stream monitor on the falling edge
  initial begin
    forever begin
      @(negedge clock);
      if (reset) begin
        beat = {bus.out_err, bus.out_eop, bus.out_sop, bus.out_data};
        if (held_valid && bus.out_valid) check("stall_hold", 64'(beat), 64'(held_beat));
        if (bus.out_valid && bus.out_ready) begin
          exp_beat = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
          check("beat", 64'(beat), 64'(exp_beat));
          beat_total++;
          if (beat_total == mark + 1) first_beat_cyc = cyc;
          last_beat_cyc = cyc;
        end
        held_valid = bus.out_valid && !bus.out_ready;
        held_beat  = beat;
      end else begin
        held_valid = 1'b0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.fifo_data  = '0;
    bus.fifo_empty = 1'b1;
    bus.out_ready  = 1'b1;
    model_reset();
    cycles(3);
    check("rst_ctrl", 64'({bus.fifo_read_enable, bus.out_valid, bus.out_sop, bus.out_eop, bus.out_err}), 64'd0);
    check("rst_data", 64'(bus.out_data), 64'd0);
    check("rst_counts", 64'({event_count, last_event_words, fsm_state}), 64'd0);
    check("rst_errs", 64'({err_orphan, err_overflow}), 64'd0);
    reset = 1'b1;
    cycles(1);

    // Basic event at full throughput
    mark = beat_total;
    send_event(3);
    drain();
    check("t1_beats", 64'(beat_total - mark), 64'd5);
    check("t1_span", 64'(last_beat_cyc - first_beat_cyc), 64'd4);
    check_stats("t1");

    // Backpressure: stall until the skid buffer fills, then toggle ready
    ready_mode = 1;
    send_event(3);
    cycles(4);
    check("t2_rd_en_full", 64'(bus.fifo_read_enable), 64'd0);
    check("t2_valid", 64'(bus.out_valid), 64'd1);
    check("t2_head", 64'({bus.out_err, bus.out_eop, bus.out_sop, bus.out_data}), 64'(exp_q[0]));
    ready_mode = 2;
    drain();
    ready_mode = 0;
    cycles(1);
    check_stats("t2");

    // Orphan word then an empty event
    mark = beat_total;
    send({1'b0, 32'hDEADBEEF});
    send({1'b1, 32'h0000_0100});
    send({1'b1, 32'h0000_0200});
    drain();
    check("t3_beats", 64'(beat_total - mark), 64'd2);
    check_stats("t3");

    // Overflow: six data words against a limit of four
    mark = beat_total;
    send_event(6);
    drain();
    check("t4_beats", 64'(beat_total - mark), 64'd6);
    check_stats("t4");

    // Reset in the middle of an event
    send({1'b1, 32'($urandom())});
    send({1'b0, 32'($urandom())});
    send({1'b0, 32'($urandom())});
    drain();
    reset = 1'b0;
    model_reset();
    exp_q.delete();
    send({1'b0, 32'($urandom())});
    send({1'b0, 32'($urandom())});
    cycles(2);
    check("t5_rd_en_rst", 64'(bus.fifo_read_enable), 64'd0);
    check("t5_out_rst", 64'({bus.out_valid, bus.out_sop, bus.out_eop, bus.out_err, bus.out_data}), 64'd0);
    check("t5_cnt_rst", 64'({event_count, last_event_words, err_orphan, err_overflow, fsm_state}), 64'd0);
    reset = 1'b1;
    cycles(1);
    send_event(1);
    drain();
    check_stats("t5");

    // Event counter wraps
    for (int i = 0; i < 8; i++) send_event($urandom_range(0, 2));
    drain();
    check_stats("t6");

    // clear_errors versus a simultaneous orphan
    clear_errors = 1'b1;
    cycles(1);
    clear_errors = 1'b0;
    m_orphan = 1'b0;
    m_ovf = 1'b0;
    check("t7_cleared", 64'({err_orphan, err_overflow}), 64'({m_orphan, m_ovf}));
    clear_errors = 1'b1;
    send({1'b0, 32'($urandom())});
    cycles(1);
    clear_errors = 1'b0;
    check("t7_set_wins", 64'(err_orphan), 64'(m_orphan));
    cycles(1);
    check("t7_still_set", 64'(err_orphan), 64'(m_orphan));
    clear_errors = 1'b1;
    cycles(1);
    clear_errors = 1'b0;
    m_orphan = 1'b0;
    check("t7_clear_idle", 64'(err_orphan), 64'(m_orphan));
    check_stats("t7");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/spy_event_reader.md
Name: spy_event_reader

Overview:
- Downstream consumer of the spy buffer's flow-control FIFO, in the read-clock domain.
- Pops words from the FIFO's first-word-fall-through read port and checks event framing. Bit DATA_WIDTH is the metadata tag: header, then data words, then footer.
- Forwards each event as a valid/ready stream with start-of-packet and end-of-packet marks.
- Keeps event and word statistics and sticky framing-error flags for monitoring.

Parameters:
- DATA_WIDTH, 32, payload width; FIFO words are DATA_WIDTH+1 bits.
- MAX_EVENT_WORDS, 1024, maximum number of data words between header and footer.
- WCOUNT_WIDTH, 11, width of the word counters; must hold MAX_EVENT_WORDS.
- ECOUNT_WIDTH, 16, width of the event counter.

Ports:
- clock  in  1  single clock, the FIFO read clock.
- reset  in  1  asynchronous active-low reset.
- fifo_data  in  DATA_WIDTH+1  FIFO read data, valid whenever fifo_empty=0.
- fifo_empty  in  1  FIFO empty flag.
- fifo_read_enable  out  1  pop strobe to the FIFO.
- out_data  out  DATA_WIDTH+1  forwarded word, including the tag bit.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts; a beat transfers when out_valid and out_ready are both 1.
- out_sop  out  1  beat is a header.
- out_eop  out  1  beat is a footer.
- out_err  out  1  footer closes a truncated event.
- event_count  out  ECOUNT_WIDTH  footers forwarded; wraps to 0.
- last_event_words  out  WCOUNT_WIDTH  data-word count of the last closed event.
- clear_errors  in  1  synchronous clear of the sticky error flags.
- err_orphan  out  1  sticky: a data word arrived outside an event.
- err_overflow  out  1  sticky: an event exceeded MAX_EVENT_WORDS.

Behaviour:
- Reset (reset=0, asynchronous):
  - all outputs 0, state IDLE, skid occupancy 0, counters 0.
  - fifo_read_enable is forced to 0 while reset is low.
  - words held in the skid buffer are discarded.
- Pop rule:
  - fifo_read_enable = !fifo_empty && occupancy<2, with occupancy taken from registers only; out_ready is not in this path.
  - every popped word is either enqueued into the 2-entry output skid buffer or dropped.
- Latency and throughput:
  - a word popped in cycle t is on out_data in cycle t+1 if the skid buffer was empty.
  - with out_ready held at 1, throughput is 1 word per cycle.
  - if out_ready=0 with out_valid=1, out_data, out_sop, out_eop and out_err hold stable.
  - the skid buffer is FIFO-ordered; a simultaneous enqueue and dequeue leaves occupancy unchanged.
- States and transitions (tag = fifo_data[DATA_WIDTH]):
  - IDLE, tag=1: forward the word with sop=1, clear the word counter, go to IN_EVENT.
  - IDLE, tag=0: drop the word, set err_orphan, stay in IDLE.
  - IN_EVENT, tag=0, counter<MAX_EVENT_WORDS: forward the word, increment the counter.
  - IN_EVENT, tag=0, counter=MAX_EVENT_WORDS: drop the word, set err_overflow, go to DROP.
  - IN_EVENT, tag=1: forward the word with eop=1, set last_event_words=counter, increment event_count, go to IDLE.
  - DROP, tag=0: drop the word.
  - DROP, tag=1: forward the word with eop=1 and err=1, set last_event_words=MAX_EVENT_WORDS, increment event_count, go to IDLE.
- State and counter updates happen at pop time, not at output-transfer time.
- A header directly followed by a footer is a legal empty event: last_event_words=0.
- event_count wraps from 2^ECOUNT_WIDTH-1 to 0 with no flag.
- Sticky error flags:
  - set has priority over clear_errors in the same cycle.
  - clear_errors does not affect state or counters.
- Reset in the middle of an event returns to IDLE. Remaining payload words then arrive as orphans and set err_orphan; the next header starts a new event.

Test Plan:
- FIFO preloaded with header, 3 data words, footer; out_ready=1 → 5 consecutive beats; sop on beat 1, eop on beat 5; event_count=1; last_event_words=3; no errors.
- Same event with out_ready toggling 1,0,1,0 → no loss or duplication; out_data stable while stalled; fifo_read_enable deasserts once occupancy reaches 2.
- Data word 0x0_DEADBEEF in IDLE, then a 0-word event → orphan dropped; err_orphan=1; 2 beats forwarded; last_event_words=0.
- MAX_EVENT_WORDS=4, event with 6 data words → 4 data words forwarded; err_overflow=1; footer has eop=1 and err=1; last_event_words=4.
- Assert reset mid-event after 2 data words, release, feed the rest plus a new event → outputs 0 during reset; leftovers set err_orphan; the new event is forwarded with a correct sop.
- clear_errors pulsed in the same cycle an orphan pops → err_orphan stays 1; a pulse on the next idle cycle clears it to 0.
